// File: rtl/snes_pkg.sv
// Shared definitions for the SNES controller port scheduler.
// Holds the sequencer state encoding, button bit positions and default timing.

package snes_pkg;

    // SNES master clock frequency the default timing is derived from
    localparam int FREQ = 21500000;

    // 6 us half-period of the pad clock, in master clock cycles
    localparam int DEF_CYC_6US = (FREQ / 100000) * 6 / 10;

    // Auto-poll interval for a 60 Hz frame rate
    localparam int DEF_POLL_PERIOD = FREQ / 60;

    // Default depth of the data-line synchronizers
    localparam int DEF_SYNC_STAGES = 2;

    // Bit positions in a 16-bit button word (0 = pressed)
    localparam int BTN_B   = 15;
    localparam int BTN_Y   = 14;
    localparam int BTN_SEL = 13;
    localparam int BTN_STA = 12;
    localparam int BTN_UP  = 11;
    localparam int BTN_DN  = 10;
    localparam int BTN_LE  = 9;
    localparam int BTN_RI  = 8;
    localparam int BTN_A   = 7;
    localparam int BTN_X   = 6;
    localparam int BTN_L   = 5;
    localparam int BTN_R   = 4;
    localparam int BTN_ID_MSB = 3;
    localparam int BTN_ID_LSB = 0;

    // Number of serial bits read from each pad per poll
    localparam int PAD_BITS = 16;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DONE  = 3'd4
    } joy_state_e;

    // Button word as seen after a full poll with no buttons pressed
    localparam logic [PAD_BITS-1:0] BTN_NONE = '1;

    // Shift one serial bit into a button word, MSB first
    function automatic logic [PAD_BITS-1:0] shift_in(
        input logic [PAD_BITS-1:0] w,
        input logic                b
    );
        return {w[PAD_BITS-2:0], b};
    endfunction

endpackage

// File: rtl/snes_joy_scheduler_sync_bit.sv
// Multi-flop synchronizer for one asynchronous pad data line, reset to 1.
// Ports: clk_i, rst_i (sync, active-high), d_i (async in), q_o (synchronized out).

module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] ff_q;

    // An idle pad line reads as released (1), so reset to that level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ff_q <= '1;
        end else begin
            ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/snes_joy_scheduler.sv
// Polls both SNES pads in lockstep with a shared latch/clock waveform.
// Ports: clk, reset, enable, poll_req in; joy*_latch/clk out; joy*_data in;
//        btns1/btns2, valid, changed1/changed2, busy out.

module snes_joy_scheduler
    import snes_pkg::*;
#(
    parameter int CYC_6US     = DEF_CYC_6US,
    parameter int POLL_PERIOD = DEF_POLL_PERIOD,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        poll_req,
    output logic        joy1_latch,
    output logic        joy1_clk,
    input  logic        joy1_data,
    output logic        joy2_latch,
    output logic        joy2_clk,
    input  logic        joy2_data,
    output logic [15:0] btns1,
    output logic [15:0] btns2,
    output logic        valid,
    output logic        changed1,
    output logic        changed2,
    output logic        busy
);

    localparam int PH_W  = $clog2(2 * CYC_6US);
    localparam int TMR_W = $clog2(POLL_PERIOD);

    localparam logic [PH_W-1:0] PH_LATCH_END = PH_W'(2 * CYC_6US - 1);
    localparam logic [PH_W-1:0] PH_HALF_END  = PH_W'(CYC_6US - 1);
    localparam logic [TMR_W-1:0] TMR_END     = TMR_W'(POLL_PERIOD - 1);
    localparam logic [3:0] LAST_BIT          = 4'(PAD_BITS - 1);

    // Synchronized pad data
    logic d1_s;
    logic d2_s;

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync1 (
        .clk_i(clk),
        .rst_i(reset),
        .d_i  (joy1_data),
        .q_o  (d1_s)
    );

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync2 (
        .clk_i(clk),
        .rst_i(reset),
        .d_i  (joy2_data),
        .q_o  (d2_s)
    );

    joy_state_e  state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [3:0]       bit_q, bit_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pend_q, pend_d;
    logic [15:0]      sh1_q, sh1_d;
    logic [15:0]      sh2_q, sh2_d;
    logic [15:0]      btns1_q, btns1_d;
    logic [15:0]      btns2_q, btns2_d;
    logic             valid_q, valid_d;
    logic             ch1_q, ch1_d;
    logic             ch2_q, ch2_d;
    logic             latch_q, latch_d;
    logic             pclk_q, pclk_d;
    logic             busy_q, busy_d;

    logic expiry;
    logic trig;
    logic start;

    assign expiry = enable && (timer_q == TMR_END);
    assign trig   = pend_q || poll_req || expiry;
    assign start  = (state_q == ST_IDLE) && trig;

    // Sequencer, shift registers and result registers
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        btns1_d = btns1_q;
        btns2_d = btns2_q;
        valid_d = 1'b0;
        ch1_d   = 1'b0;
        ch2_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_LATCH;
                    ph_d    = '0;
                    bit_d   = '0;
                end
            end
            ST_LATCH: begin
                if (ph_q == PH_LATCH_END) begin
                    state_d = ST_LOW;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_LOW: begin
                // Sample at the end of the low phase, when the
                // line has long settled after the previous rise
                if (ph_q == PH_HALF_END) begin
                    sh1_d   = shift_in(sh1_q, d1_s);
                    sh2_d   = shift_in(sh2_q, d2_s);
                    state_d = ST_HIGH;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_HIGH: begin
                if (ph_q == PH_HALF_END) begin
                    ph_d = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOW;
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_DONE: begin
                // Change flags compare against the words being replaced
                btns1_d = sh1_q;
                btns2_d = sh2_q;
                valid_d = 1'b1;
                ch1_d   = (sh1_q != btns1_q);
                ch2_d   = (sh2_q != btns2_q);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame timer and one-deep request latch
    always_comb begin
        timer_d = timer_q;
        pend_d  = pend_q;

        if (start) begin
            timer_d = '0;
        end else if (enable) begin
            // Expiry while busy wraps silently; it is not queued
            timer_d = expiry ? '0 : timer_q + TMR_W'(1);
        end

        if (start) begin
            pend_d = 1'b0;
        end else if (poll_req && (state_q != ST_IDLE)) begin
            pend_d = 1'b1;
        end
    end

    // Pad pins are registered from the next state so they never glitch
    always_comb begin
        latch_d = (state_d == ST_LATCH);
        pclk_d  = (state_d != ST_LOW);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            timer_q <= '0;
            pend_q  <= 1'b0;
            sh1_q   <= BTN_NONE;
            sh2_q   <= BTN_NONE;
            btns1_q <= BTN_NONE;
            btns2_q <= BTN_NONE;
            valid_q <= 1'b0;
            ch1_q   <= 1'b0;
            ch2_q   <= 1'b0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            btns1_q <= btns1_d;
            btns2_q <= btns2_d;
            valid_q <= valid_d;
            ch1_q   <= ch1_d;
            ch2_q   <= ch2_d;
            latch_q <= latch_d;
            pclk_q  <= pclk_d;
            busy_q  <= busy_d;
        end
    end

    assign joy1_latch = latch_q;
    assign joy2_latch = latch_q;
    assign joy1_clk   = pclk_q;
    assign joy2_clk   = pclk_q;
    assign btns1      = btns1_q;
    assign btns2      = btns2_q;
    assign valid      = valid_q;
    assign changed1   = ch1_q;
    assign changed2   = ch2_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_snes_joy_scheduler.sv
// Scoreboard bench for snes_joy_scheduler with behavioural pad models.
// Ports of the DUT are all driven/observed here.

module tb_snes_joy_scheduler;

    localparam int CYC = 4;
    localparam int PP  = 400;
    localparam int SS  = 2;
    localparam int POLL_LAT = 1 + 2 * CYC + 32 * CYC + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        poll_req = 1'b0;
    logic        joy1_latch, joy1_clk, joy1_data;
    logic        joy2_latch, joy2_clk, joy2_data;
    logic [15:0] btns1, btns2;
    logic        valid, changed1, changed2, busy;

    snes_joy_scheduler #(
        .CYC_6US    (CYC),
        .POLL_PERIOD(PP),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .poll_req  (poll_req),
        .joy1_latch(joy1_latch),
        .joy1_clk  (joy1_clk),
        .joy1_data (joy1_data),
        .joy2_latch(joy2_latch),
        .joy2_clk  (joy2_clk),
        .joy2_data (joy2_data),
        .btns1     (btns1),
        .btns2     (btns2),
        .valid     (valid),
        .changed1  (changed1),
        .changed2  (changed2),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Pad models: parallel load while latched, shift on each clock rise
    logic [15:0] pad1_w = 16'hFFFF;
    logic [15:0] pad2_w = 16'hFFFF;
    logic [15:0] ps1 = 16'hFFFF;
    logic [15:0] ps2 = 16'hFFFF;

    always @(posedge joy1_clk or posedge joy1_latch)
        if (joy1_latch) ps1 = pad1_w;
        else ps1 = {ps1[14:0], 1'b0};

    always @(posedge joy2_clk or posedge joy2_latch)
        if (joy2_latch) ps2 = pad2_w;
        else ps2 = {ps2[14:0], 1'b0};

    assign joy1_data = ps1[15];
    assign joy2_data = ps2[15];

    // Reference: each latched poll reports the pad words; change flags
    // compare against the last reported words
    typedef struct {
        logic [15:0] b1;
        logic [15:0] b2;
        logic        c1;
        logic        c2;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] m1 = 16'hFFFF;
    logic [15:0] m2 = 16'hFFFF;

    always @(posedge joy1_latch) begin
        exp_t e;
        e.b1 = pad1_w;
        e.b2 = pad2_w;
        e.c1 = (pad1_w != m1);
        e.c2 = (pad2_w != m2);
        m1 = pad1_w;
        m2 = pad2_w;
        sbq.push_back(e);
    end

    // Monitor
    int valq[$];
    int nvalid = 0;
    int nlatch = 0;
    int lrun = 0;
    int crun = 0;
    int npulse = 0;
    int mirror_err = 0;
    int stray_err = 0;

    always @(negedge clk) begin
        exp_t e;
        if (joy1_latch !== joy2_latch || joy1_clk !== joy2_clk)
            mirror_err++;
        if (reset) begin
            lrun = 0;
            crun = 0;
        end else begin
            if (joy1_latch) begin
                if (lrun == 0) nlatch++;
                lrun++;
            end else if (lrun != 0) begin
                chk("latch_len", lrun, 2 * CYC);
                lrun = 0;
                npulse = 0;
            end
            if (!joy1_clk) begin
                crun++;
            end else if (crun != 0) begin
                chk("clk_low_len", crun, CYC);
                npulse++;
                crun = 0;
            end
            if (valid) begin
                chk("clk_pulses", npulse, 16);
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: valid with no expected poll, cyc %0d",
                             cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("btns1", btns1, e.b1);
                    chk("btns2", btns2, e.b2);
                    chk("changed1", changed1, e.c1);
                    chk("changed2", changed2, e.c2);
                end
                valq.push_back(cyc);
                nvalid++;
            end else if (changed1 || changed2) begin
                stray_err++;
            end
        end
    end

    task automatic wait_polls(input int n, input int budget);
        int s;
        s = nvalid;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (nvalid >= s + n) break;
        end
        chk("wait_valid", nvalid - s, n);
    endtask

    task automatic pulse_req(output int at);
        @(posedge clk);
        #1;
        poll_req = 1'b1;
        at = cyc;
        @(posedge clk);
        #1;
        poll_req = 1'b0;
    endtask

    task automatic goto_cyc(input int t);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < t);
    endtask

    task automatic rand_pads();
        if ($urandom_range(0, 2) != 0) pad1_w = 16'($urandom);
        if ($urandom_range(0, 2) != 0) pad2_w = 16'($urandom);
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, v, n0, n1;

        // Reset and idle
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_latch", joy1_latch, 1'b0);
        chk("rst_clk", joy1_clk, 1'b1);
        chk("rst_btns1", btns1, 16'hFFFF);
        chk("rst_btns2", btns2, 16'hFFFF);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        repeat (1000) @(negedge clk);
        chk("idle_polls", nlatch, 0);
        chk("idle_valids", nvalid, 0);
        chk("idle_clk", joy1_clk, 1'b1);

        // Single on-demand poll, B pressed on pad 1
        pad1_w = 16'h7FFF;
        pad2_w = 16'hFFFF;
        pulse_req(r);
        wait_polls(1, 300);
        chk("req_latency", valq[$] - r, POLL_LAT);
        chk("busy_after", busy, 1'b0);

        // Auto polling with static pads
        pad1_w = 16'hF7FF;
        pad2_w = 16'hF7FF;
        enable = 1'b1;
        wait_polls(3, 1500);
        chk("auto_period_a", valq[$] - valq[$-1], PP);
        chk("auto_period_b", valq[$-1] - valq[$-2], PP);

        // Auto polling with random pad words between polls
        for (int i = 0; i < 4; i++) begin
            rand_pads();
            wait_polls(1, 600);
            chk("rand_period", valq[$] - valq[$-1], PP);
        end
        enable = 1'b0;
        repeat (10) @(negedge clk);

        // Requests while busy merge into one extra poll
        rand_pads();
        pulse_req(r);
        repeat (20) @(posedge clk);
        pulse_req(v);
        repeat (40) @(posedge clk);
        pulse_req(v);
        wait_polls(2, 700);
        chk("pending_gap", valq[$] - valq[$-1], POLL_LAT);
        n0 = nvalid;
        repeat (600) @(negedge clk);
        chk("no_third_poll", nvalid - n0, 0);

        // Reset in the middle of a poll
        pad1_w = 16'h1234;
        pad2_w = 16'hABCD;
        pulse_req(r);
        repeat (48) @(posedge clk);
        #1;
        reset = 1'b1;
        sbq.delete();
        m1 = 16'hFFFF;
        m2 = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        chk("abort_latch", joy1_latch, 1'b0);
        chk("abort_clk", joy1_clk, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_btns1", btns1, 16'hFFFF);
        chk("abort_btns2", btns2, 16'hFFFF);
        #1;
        reset = 1'b0;
        n0 = nvalid;
        repeat (300) @(negedge clk);
        chk("abort_no_valid", nvalid - n0, 0);

        // Request landing on the same cycle as a timer expiry
        enable = 1'b1;
        wait_polls(1, 600);
        v = valq[$];
        goto_cyc(v + PP - POLL_LAT);
        n0 = nlatch;
        poll_req = 1'b1;
        @(posedge clk);
        #1;
        poll_req = 1'b0;
        wait_polls(1, 600);
        n1 = nlatch;
        chk("coincide_cyc", valq[$] - v, PP);
        chk("coincide_one", n1 - n0, 1);

        // Request mid-frame restarts the frame timer
        v = valq[$];
        rand_pads();
        goto_cyc(v + 100);
        r = cyc;
        poll_req = 1'b1;
        @(posedge clk);
        #1;
        poll_req = 1'b0;
        wait_polls(1, 300);
        chk("req_latency2", valq[$] - r, POLL_LAT);
        wait_polls(1, 600);
        chk("timer_cleared", valq[$] - r, PP + POLL_LAT);
        enable = 1'b0;
        repeat (200) @(negedge clk);

        chk("pin_mirror", mirror_err, 0);
        chk("stray_changed", stray_err, 0);
        chk("sb_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
